// File: rtl/tap_capture_sched.sv
// Epoch scheduler and round-robin collector for a bank of capture taps.
// A programmable period timer toggles global_ping once per epoch; within each
// epoch every valid tap is granted at most once onto a single valid/ready
// stream. Taps still pending when the epoch closes are flagged as overruns.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | scheduler off: timer parked at 0, no grants, global_ping frozen
//   RUN   | timer counting epochs, arbiter granting pending valid taps
module tap_capture_sched #(
  parameter int NUM_TAPS    = 4,
  parameter int DATA_WIDTH  = 40,
  parameter int TIMER_WIDTH = 8,
  parameter int EPOCH_WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cfg_en,
  input  logic [TIMER_WIDTH-1:0]         cfg_period,
  input  logic                           clr_overrun,
  output logic                           global_ping,
  input  logic [NUM_TAPS-1:0]            tap_valid,
  input  logic [NUM_TAPS*DATA_WIDTH-1:0] tap_data,
  output logic [NUM_TAPS-1:0]            tap_ack,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [DATA_WIDTH-1:0]          m_data,
  output logic [$clog2(NUM_TAPS)-1:0]    m_tap_id,
  output logic [EPOCH_WIDTH-1:0]         epoch,
  output logic                           overrun,
  output logic [NUM_TAPS-1:0]            overrun_mask
);

  localparam int ID_WIDTH = $clog2(NUM_TAPS);
  localparam logic [ID_WIDTH:0]   NUM_TAPS_W = (ID_WIDTH+1)'(NUM_TAPS);
  localparam logic [ID_WIDTH-1:0] LAST_TAP   = ID_WIDTH'(NUM_TAPS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                 state_q, state_d;
  logic [TIMER_WIDTH-1:0] timer_q, timer_d;
  logic [NUM_TAPS-1:0]    pending_q, pending_d;
  logic [ID_WIDTH-1:0]    rr_ptr_q, rr_ptr_d;
  logic                   ping_q, ping_d;
  logic [EPOCH_WIDTH-1:0] epoch_q, epoch_d;
  logic                   overrun_q, overrun_d;
  logic [NUM_TAPS-1:0]    ovr_mask_q, ovr_mask_d;
  logic [NUM_TAPS-1:0]    tap_ack_q, tap_ack_d;
  logic                   m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0]  m_data_q, m_data_d;
  logic [ID_WIDTH-1:0]    m_tap_id_q, m_tap_id_d;

  logic [DATA_WIDTH-1:0]  tap_word [NUM_TAPS];
  logic [NUM_TAPS-1:0]    eligible;
  logic                   grant_found;
  logic [ID_WIDTH-1:0]    grant_idx;
  logic [ID_WIDTH:0]      cand;
  logic                   run_active;
  logic                   slot_free;
  logic                   grant;
  logic [NUM_TAPS-1:0]    grant_onehot;
  logic [NUM_TAPS-1:0]    pending_left;
  logic [TIMER_WIDTH-1:0] period_eff;

  // Unpack the flat tap bus into one word per tap.
  always_comb begin
    for (int i = 0; i < NUM_TAPS; i++) begin
      tap_word[i] = tap_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Round-robin search: first eligible tap at or above rr_ptr, wrapping.
  always_comb begin
    eligible    = tap_valid & pending_q;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < NUM_TAPS; i++) begin
      cand = {1'b0, rr_ptr_q} + (ID_WIDTH+1)'(i);
      if (cand >= NUM_TAPS_W) begin
        cand = cand - NUM_TAPS_W;
      end
      if (!grant_found && eligible[cand[ID_WIDTH-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[ID_WIDTH-1:0];
      end
    end
  end

  // Grant qualification; dropping cfg_en blocks grants in the same cycle.
  always_comb begin
    run_active   = (state_q == RUN) && cfg_en;
    slot_free    = !m_valid_q || m_ready;
    grant        = run_active && slot_free && grant_found;
    grant_onehot = grant ? (NUM_TAPS'(1) << grant_idx) : '0;
    pending_left = pending_q & ~grant_onehot;
    period_eff   = (cfg_period == '0) ? TIMER_WIDTH'(1) : cfg_period;
  end

  // Next-state: FSM, epoch timer, pending/overrun bookkeeping, output slot.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    ping_d     = ping_q;
    epoch_d    = epoch_q;
    pending_d  = pending_left;
    rr_ptr_d   = rr_ptr_q;
    overrun_d  = clr_overrun ? 1'b0 : overrun_q;
    ovr_mask_d = clr_overrun ? '0 : ovr_mask_q;
    tap_ack_d  = grant_onehot;
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;
    m_tap_id_d = m_tap_id_q;

    case (state_q)
      IDLE: begin
        if (cfg_en) begin
          state_d   = RUN;
          pending_d = '1;
        end
      end
      RUN: begin
        if (!cfg_en) begin
          state_d   = IDLE;
          timer_d   = '0;
          pending_d = '0;
        // >= rather than == so a live shrink of cfg_period below the
        // current count closes the epoch instead of wrapping the timer.
        end else if (timer_q >= period_eff) begin
          timer_d   = '0;
          ping_d    = ~ping_q;
          epoch_d   = epoch_q + 1'b1;
          pending_d = '1;
          if (|pending_left) begin
            overrun_d  = 1'b1;
            ovr_mask_d = ovr_mask_d | pending_left;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (grant) begin
      m_valid_d  = 1'b1;
      m_data_d   = tap_word[grant_idx];
      m_tap_id_d = grant_idx;
      rr_ptr_d   = (grant_idx == LAST_TAP) ? '0 : grant_idx + 1'b1;
    end else if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      pending_q  <= '0;
      rr_ptr_q   <= '0;
      ping_q     <= 1'b0;
      epoch_q    <= '0;
      overrun_q  <= 1'b0;
      ovr_mask_q <= '0;
      tap_ack_q  <= '0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_tap_id_q <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      pending_q  <= pending_d;
      rr_ptr_q   <= rr_ptr_d;
      ping_q     <= ping_d;
      epoch_q    <= epoch_d;
      overrun_q  <= overrun_d;
      ovr_mask_q <= ovr_mask_d;
      tap_ack_q  <= tap_ack_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      m_tap_id_q <= m_tap_id_d;
    end
  end

  assign global_ping  = ping_q;
  assign tap_ack      = tap_ack_q;
  assign m_valid      = m_valid_q;
  assign m_data       = m_data_q;
  assign m_tap_id     = m_tap_id_q;
  assign epoch        = epoch_q;
  assign overrun      = overrun_q;
  assign overrun_mask = ovr_mask_q;

endmodule

// File: tb/tb_tap_capture_sched.sv
// Directed bench for tap_capture_sched: epoch timing, round-robin collection,
// back-pressure, overrun flagging, disable/drain and asynchronous reset.
module tb_tap_capture_sched;

  localparam int NT = 4;
  localparam int DW = 40;
  localparam int TW = 8;
  localparam int EW = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cfg_en;
  logic [TW-1:0]   cfg_period;
  logic            clr_overrun;
  logic            global_ping;
  logic [NT-1:0]   tap_valid;
  logic [NT*DW-1:0] tap_data;
  logic [NT-1:0]   tap_ack;
  logic            m_valid;
  logic            m_ready;
  logic [DW-1:0]   m_data;
  logic [1:0]      m_tap_id;
  logic [EW-1:0]   epoch;
  logic            overrun;
  logic [NT-1:0]   overrun_mask;

  int errors = 0;
  int checks = 0;
  int n;

  tap_capture_sched #(
    .NUM_TAPS(NT), .DATA_WIDTH(DW), .TIMER_WIDTH(TW), .EPOCH_WIDTH(EW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en), .cfg_period(cfg_period),
    .clr_overrun(clr_overrun), .global_ping(global_ping),
    .tap_valid(tap_valid), .tap_data(tap_data), .tap_ack(tap_ack),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_tap_id(m_tap_id), .epoch(epoch), .overrun(overrun),
    .overrun_mask(overrun_mask)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] word(input int i);
    return 40'hA5_0000_0000 + 40'h11_1111_1111 * DW'(i);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_toggle(output int cnt);
    logic start;
    start = global_ping;
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (global_ping === start && cnt < 64);
  endtask

  initial begin
    rst_n = 1'b0; cfg_en = 1'b1; cfg_period = 8'd3; clr_overrun = 1'b0;
    tap_valid = '0; m_ready = 1'b1;
    for (int i = 0; i < NT; i++) tap_data[i*DW +: DW] = word(i);

    // reset values
    #12;
    chk("rst_ping", 64'(global_ping), 64'd0);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_tap_ack", 64'(tap_ack), 64'd0);
    chk("rst_m_data", 64'(m_data), 64'd0);
    chk("rst_m_tap_id", 64'(m_tap_id), 64'd0);
    chk("rst_epoch", 64'(epoch), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);
    chk("rst_overrun_mask", 64'(overrun_mask), 64'd0);
    #8 rst_n = 1'b1;

    // epoch timer, period 3 then period 0; no taps valid so every tap overruns
    wait_toggle(n);
    chk("first_toggle_latency", 64'(n), 64'd5);
    chk("epoch_1", 64'(epoch), 64'd1);
    chk("ping_1", 64'(global_ping), 64'd1);
    chk("idle_taps_overrun", 64'(overrun), 64'd1);
    chk("idle_taps_mask", 64'(overrun_mask), 64'hf);
    wait_toggle(n);
    chk("period3_interval_a", 64'(n), 64'd4);
    chk("epoch_2", 64'(epoch), 64'd2);
    wait_toggle(n);
    chk("period3_interval_b", 64'(n), 64'd4);
    chk("epoch_3", 64'(epoch), 64'd3);
    cfg_period = 8'd0;
    wait_toggle(n);
    chk("period0_interval_a", 64'(n), 64'd2);
    chk("epoch_4", 64'(epoch), 64'd4);
    wait_toggle(n);
    chk("period0_interval_b", 64'(n), 64'd2);
    chk("epoch_5", 64'(epoch), 64'd5);

    // all taps valid, m_ready high: one word per cycle in tap order
    tap_valid = 4'b1111; cfg_period = 8'd5; clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    chk("s2_valid0", 64'(m_valid), 64'd1);
    chk("s2_id0", 64'(m_tap_id), 64'd0);
    chk("s2_data0", 64'(m_data), 64'(word(0)));
    chk("s2_ack0", 64'(tap_ack), 64'h1);
    chk("clr_overrun", 64'(overrun), 64'd0);
    chk("clr_overrun_mask", 64'(overrun_mask), 64'd0);
    step();
    chk("s2_id1", 64'(m_tap_id), 64'd1);
    chk("s2_ack1", 64'(tap_ack), 64'h2);
    chk("s2_data1", 64'(m_data), 64'(word(1)));
    step();
    chk("s2_id2", 64'(m_tap_id), 64'd2);
    chk("s2_ack2", 64'(tap_ack), 64'h4);
    step();
    chk("s2_id3", 64'(m_tap_id), 64'd3);
    chk("s2_ack3", 64'(tap_ack), 64'h8);
    chk("s2_data3", 64'(m_data), 64'(word(3)));
    step();
    chk("s2_drain_valid", 64'(m_valid), 64'd0);
    chk("s2_drain_ack", 64'(tap_ack), 64'd0);
    step();
    chk("s2_no_regrant_valid", 64'(m_valid), 64'd0);
    chk("s2_no_regrant_ack", 64'(tap_ack), 64'd0);
    chk("s2_ping", 64'(global_ping), 64'd0);
    chk("s2_epoch", 64'(epoch), 64'd6);
    chk("s2_no_overrun", 64'(overrun), 64'd0);

    // back-pressure for 5 cycles holds the first word
    m_ready = 1'b0;
    step();
    chk("s3_valid", 64'(m_valid), 64'd1);
    chk("s3_id", 64'(m_tap_id), 64'd0);
    chk("s3_ack", 64'(tap_ack), 64'h1);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("s3_hold_valid", 64'(m_valid), 64'd1);
      chk("s3_hold_id", 64'(m_tap_id), 64'd0);
      chk("s3_hold_data", 64'(m_data), 64'(word(0)));
      chk("s3_hold_ack", 64'(tap_ack), 64'd0);
    end
    m_ready = 1'b1;
    step();
    chk("s3_release_id", 64'(m_tap_id), 64'd1);
    chk("s3_release_ack", 64'(tap_ack), 64'h2);
    chk("s3_ping", 64'(global_ping), 64'd1);
    chk("s3_epoch", 64'(epoch), 64'd7);
    chk("s3_overrun", 64'(overrun), 64'd1);
    chk("s3_overrun_mask", 64'(overrun_mask), 64'hc);
    step();
    chk("s3_rr_id", 64'(m_tap_id), 64'd2);
    chk("s3_rr_ack", 64'(tap_ack), 64'h4);

    // tap 2 never valid, period 2
    tap_valid = 4'b1011; cfg_period = 8'd2;
    wait_toggle(n);
    chk("s4_sync_interval", 64'(n), 64'd2);
    chk("s4_sync_epoch", 64'(epoch), 64'd8);
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    chk("s4_clr_overrun", 64'(overrun), 64'd0);
    chk("s4_clr_mask", 64'(overrun_mask), 64'd0);
    step();
    step();
    chk("s4_ping", 64'(global_ping), 64'd1);
    chk("s4_epoch", 64'(epoch), 64'd9);
    chk("s4_overrun", 64'(overrun), 64'd1);
    chk("s4_mask", 64'(overrun_mask), 64'h4);
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    chk("s4_clr2_overrun", 64'(overrun), 64'd0);
    chk("s4_clr2_mask", 64'(overrun_mask), 64'd0);
    step();
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    chk("s4_set_wins_overrun", 64'(overrun), 64'd1);
    chk("s4_set_wins_mask", 64'(overrun_mask), 64'h4);
    chk("s4_epoch2", 64'(epoch), 64'd10);
    chk("s4_last_id", 64'(m_tap_id), 64'd0);

    // disable mid-stream: word drains, no grants, ping frozen
    m_ready = 1'b0; cfg_en = 1'b0;
    step();
    chk("s5_held_valid", 64'(m_valid), 64'd1);
    chk("s5_held_data", 64'(m_data), 64'(word(0)));
    chk("s5_no_ack", 64'(tap_ack), 64'd0);
    repeat (3) step();
    chk("s5_still_valid", 64'(m_valid), 64'd1);
    m_ready = 1'b1;
    step();
    chk("s5_drained", 64'(m_valid), 64'd0);
    repeat (3) step();
    chk("s5_idle_valid", 64'(m_valid), 64'd0);
    chk("s5_idle_ack", 64'(tap_ack), 64'd0);
    chk("s5_ping_frozen", 64'(global_ping), 64'd0);
    chk("s5_epoch_frozen", 64'(epoch), 64'd10);
    cfg_en = 1'b1;
    step();
    chk("s5_enable_no_grant", 64'(m_valid), 64'd0);
    step();
    chk("s5_regrant_id", 64'(m_tap_id), 64'd1);
    chk("s5_regrant_ack", 64'(tap_ack), 64'h2);
    step();
    chk("s5_regrant_id2", 64'(m_tap_id), 64'd3);
    step();
    chk("s5_restart_ping", 64'(global_ping), 64'd1);
    chk("s5_restart_epoch", 64'(epoch), 64'd11);

    // asynchronous reset with a word in flight
    m_ready = 1'b0;
    step();
    chk("s6_pre_valid", 64'(m_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("s6_rst_ping", 64'(global_ping), 64'd0);
    chk("s6_rst_valid", 64'(m_valid), 64'd0);
    chk("s6_rst_ack", 64'(tap_ack), 64'd0);
    chk("s6_rst_data", 64'(m_data), 64'd0);
    chk("s6_rst_epoch", 64'(epoch), 64'd0);
    chk("s6_rst_overrun", 64'(overrun), 64'd0);
    chk("s6_rst_mask", 64'(overrun_mask), 64'd0);
    step();
    step();
    rst_n = 1'b1; m_ready = 1'b1;
    step();
    chk("s6_post_idle_valid", 64'(m_valid), 64'd0);
    step();
    chk("s6_first_valid", 64'(m_valid), 64'd1);
    chk("s6_first_id", 64'(m_tap_id), 64'd0);
    chk("s6_first_ack", 64'(tap_ack), 64'h1);
    chk("s6_first_data", 64'(m_data), 64'(word(0)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tap_capture_sched.md
Name: tap_capture_sched

Overview:
- Scheduler/arbiter for a bank of tap_test-style capture taps.
- Generates the shared global_ping epoch toggle from a programmable period timer.
- Round-robin collects one captured word per tap per epoch onto a single valid/ready stream.
- Flags taps that miss their epoch.
- Sits between the tap bank and the debug/readout path.

Parameters:
- NUM_TAPS, 4, number of tap requesters (2..16).
- DATA_WIDTH, 40, width of each tap's out_data word.
- TIMER_WIDTH, 8, width of the epoch period counter.
- EPOCH_WIDTH, 16, width of the epoch counter.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_en  in  1  scheduler enable.
- cfg_period  in  TIMER_WIDTH  epoch length minus one, in cycles.
- clr_overrun  in  1  one-cycle pulse, clears overrun and overrun_mask.
- global_ping  out  1  epoch level; toggles once per epoch.
- tap_valid  in  NUM_TAPS  tap i holds a captured word.
- tap_data  in  NUM_TAPS*DATA_WIDTH  tap i word at bits [i*DATA_WIDTH +: DATA_WIDTH].
- tap_ack  out  NUM_TAPS  one-cycle pulse, word of tap i taken.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accepts.
- m_data  out  DATA_WIDTH  collected word.
- m_tap_id  out  $clog2(NUM_TAPS)  source tap of m_data.
- epoch  out  EPOCH_WIDTH  count of ping toggles, wraps.
- overrun  out  1  sticky: some tap unserviced at epoch end.
- overrun_mask  out  NUM_TAPS  sticky per-tap overrun.

Behaviour:
- Reset values: global_ping=0, tap_ack=0, m_valid=0, m_data=0, m_tap_id=0, epoch=0, overrun=0, overrun_mask=0. Internal: timer=0, pending=0, rr_ptr=0, state=IDLE.
- Async reset mid-transfer drops m_valid immediately. No tap_ack is issued for a word in flight.

State machine:
- IDLE -> RUN when cfg_en=1. On this transition pending is set to all ones.
- RUN -> IDLE when cfg_en=0. On this transition: timer=0, pending=0, global_ping holds its level, and an already-valid m_data still drains.

Epoch timer (RUN state only):
- Effective period P = max(cfg_period,1).
- timer counts 0..P. At timer==P the following happen in the same cycle: timer<=0, global_ping toggles, epoch increments, pending<=all ones.
- Toggle interval is P+1 cycles.
- cfg_period is sampled live; a change takes effect at the next compare.

Overrun:
- At an epoch boundary, any bit of pending still set (after removing a tap granted that same cycle) ORs into overrun_mask and sets overrun.
- The pending reload has priority over the grant's clear.
- clr_overrun clears overrun and overrun_mask. If clr_overrun coincides with a new overrun, the set wins.

Arbitration:
- Runs in RUN state only.
- Eligible taps: tap_valid & pending.
- Output slot is free when m_valid==0, or when m_valid==1 && m_ready==1.
- If the slot is free and any tap is eligible, grant the first eligible index searching upward from rr_ptr, wrapping.
- Maximum one grant per cycle.
- On grant g, registered in the same edge:
  - m_data <= tap g word.
  - m_tap_id <= g.
  - m_valid <= 1.
  - tap_ack[g] = 1 for exactly one cycle.
  - pending[g] <= 0.
  - rr_ptr <= g+1 mod NUM_TAPS.
- m_valid, m_data and m_tap_id hold stable while m_valid && !m_ready.
- m_valid falls after a handshake with no new grant.
- Throughput: one word per cycle with m_ready held high.
- A tap with tap_valid=0 is skipped. It is never granted twice in one epoch.

Test Plan:
1. rst_n low 20ns, cfg_en=1, cfg_period=3 -> global_ping toggles every 4 cycles; epoch counts 1,2,3...; cfg_period=0 gives toggles every 2 cycles.
2. All four tap_valid=1 from the first epoch, m_ready=1 -> m_tap_id 0,1,2,3 on consecutive cycles; one tap_ack pulse each; no further grants until the next toggle.
3. Same as scenario 2 with m_ready=0 for 5 cycles -> m_valid=1, m_tap_id=0 and m_data stable; no second tap_ack until m_ready=1.
4. cfg_period=2, tap 2 never valid -> at the next toggle overrun=1 and overrun_mask=4'b0100; clr_overrun clears both; they re-set at the following toggle.
5. cfg_en dropped mid-epoch with m_valid=1 -> word drains on m_ready; no new grants; global_ping frozen; timer restarts from 0 when re-enabled.
6. Assert rst_n=0 while m_valid=1 and a tap is pending -> all outputs return to reset values asynchronously; first grant after reset goes to tap 0.
